// File: rtl/uart_pkg.sv
// uart_pkg: register map offsets, STATUS bit positions and FSM encoding
// shared by the MMIO UART transmitter.
package uart_pkg;
    localparam logic [31:0] TXDATA_OFS = 32'h0;
    localparam logic [31:0] STATUS_OFS = 32'h4;
    localparam int FULL_B    = 0;
    localparam int EMPTY_B   = 1;
    localparam int BUSY_B    = 2;
    localparam int OVF_B     = 3;
    localparam int COUNT_LSB = 8;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: power-of-two circular FIFO; a push into a full FIFO is still
// accepted when a pop frees a slot on the same edge.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           push,
    input  logic [WIDTH-1:0]               din,
    input  logic                           pop,
    output logic [WIDTH-1:0]               dout,
    output logic [$clog2(DEPTH+1)-1:0]     count,
    output logic                           full,
    output logic                           empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0] wp_q, rp_q;
    logic [CW-1:0] cnt_q;
    logic do_push, do_pop;
    assign full    = cnt_q == CW'(DEPTH);
    assign empty   = cnt_q == '0;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem_q[rp_q];
    assign count   = cnt_q;
    always_ff @(posedge clk) begin
        if (do_push && !reset) mem_q[wp_q] <= din;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wp_q <= wp_q + 1'b1;
            if (do_pop) rp_q <= rp_q + 1'b1;
            cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter with a small byte FIFO,
// sitting beside dmem on the processor data port.
module mmio_uart_tx
    import uart_pkg::*;
#(
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 4,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_FF00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [31:0] a,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        txd
);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int CW = $clog2(FIFO_DEPTH+1);
    localparam logic [31:0] TX_A = BASE_ADDR + TXDATA_OFS;
    localparam logic [31:0] ST_A = BASE_ADDR + STATUS_OFS;
    uart_state_t   state_q;
    logic [BW-1:0] bcnt_q;
    logic [2:0]    bidx_q;
    logic [7:0]    sh_q, dout;
    logic          ovf_q, txd_q;
    logic [CW-1:0] count;
    logic [31:0]   status;
    logic full, empty, sel_tx, sel_st, push, pop, last;
    logic unused_bits;
    assign unused_bits = ^{a[1:0], wd[31:8]};
    assign sel_tx = a[31:2] == TX_A[31:2];
    assign sel_st = a[31:2] == ST_A[31:2];
    assign push   = we && sel_tx;
    assign last   = bcnt_q == BW'(CLKS_PER_BIT-1);
    // the next byte is taken either from idle or at the end of a stop bit
    assign pop    = !empty && (state_q == IDLE || (state_q == STOP && last));
    assign txd    = txd_q;
    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk), .reset(reset), .push(push), .din(wd[7:0]), .pop(pop),
        .dout(dout), .count(count), .full(full), .empty(empty)
    );
    always_comb begin
        status = '0;
        status[FULL_B]  = full;
        status[EMPTY_B] = empty;
        status[BUSY_B]  = state_q != IDLE;
        status[OVF_B]   = ovf_q;
        status[COUNT_LSB +: 8] = 8'(count);
        rd = sel_st ? status : '0;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            txd_q   <= 1'b1;
            ovf_q   <= 1'b0;
            bcnt_q  <= '0;
            bidx_q  <= '0;
            sh_q    <= '0;
        end else begin
            if (push && full && !pop) ovf_q <= 1'b1;
            else if (we && sel_st && wd[OVF_B]) ovf_q <= 1'b0;
            bcnt_q <= (state_q == IDLE || last) ? '0 : bcnt_q + 1'b1;
            case (state_q)
                IDLE: if (pop) begin
                    sh_q    <= dout;
                    state_q <= START;
                    txd_q   <= 1'b0;
                end
                START: if (last) begin
                    bidx_q  <= '0;
                    state_q <= DATA;
                    txd_q   <= sh_q[0];
                end
                DATA: if (last) begin
                    sh_q <= sh_q >> 1;
                    if (bidx_q == 3'd7) begin
                        state_q <= STOP;
                        txd_q   <= 1'b1;
                    end else begin
                        bidx_q <= bidx_q + 1'b1;
                        txd_q  <= sh_q[1];
                    end
                end
                STOP: if (last) begin
                    if (pop) begin
                        sh_q    <= dout;
                        state_q <= START;
                        txd_q   <= 1'b0;
                    end else begin
                        state_q <= IDLE;
                    end
                end
            endcase
        end
    end
endmodule
